// File: rtl/regfile_wb_sched_if.sv
// Bundle of signals between the decode/writeback pipeline and the register-file
// write-port scheduler. master = pipeline side, slave = scheduler.
interface regfile_wb_sched_if;
  logic        pipe_wb_valid;
  logic [4:0]  pipe_wb_rd;
  logic [31:0] pipe_wb_data;
  logic        ll_issue_valid;
  logic [4:0]  ll_issue_rd;
  logic        ll_wb_valid;
  logic [4:0]  ll_wb_rd;
  logic [31:0] ll_wb_data;
  logic        ll_wb_ready;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        RegWrite;
  logic [4:0]  rd;
  logic [31:0] rd_write_data;
  logic        src_stall;
  logic        issue_stall;
  logic        pipe_hold;
  logic [31:0] busy;

  modport master (
    output pipe_wb_valid, pipe_wb_rd, pipe_wb_data,
    output ll_issue_valid, ll_issue_rd,
    output ll_wb_valid, ll_wb_rd, ll_wb_data,
    output rs1, rs2,
    input  ll_wb_ready, RegWrite, rd, rd_write_data,
    input  src_stall, issue_stall, pipe_hold, busy
  );

  modport slave (
    input  pipe_wb_valid, pipe_wb_rd, pipe_wb_data,
    input  ll_issue_valid, ll_issue_rd,
    input  ll_wb_valid, ll_wb_rd, ll_wb_data,
    input  rs1, rs2,
    output ll_wb_ready, RegWrite, rd, rd_write_data,
    output src_stall, issue_stall, pipe_hold, busy
  );
endinterface

// File: rtl/regfile_wb_sched.sv
// Arbitrates the single register-file write port between the fixed-priority
// pipeline writeback and buffered long-latency results; tracks busy registers.
module regfile_wb_sched #(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input logic              clk,
  input logic              rst,
  regfile_wb_sched_if.slave bus
);
  localparam int DATA_W = 32;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int STV_W  = $clog2(STARVE_LIMIT + 1);

  logic [4:0]        fifo_rd   [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [CNT_W-1:0]  count;
  logic [STV_W-1:0]  starve, starve_next;
  logic [31:0]       busy_q, busy_next;
  logic              pipe_hold_q;

  logic              pop, bypass, push, ll_ready, commit, reg_write;
  logic              sel_valid;
  logic [4:0]        sel_rd, commit_rd;
  logic [DATA_W-1:0] sel_data;
  logic              full;

  function automatic logic [STV_W-1:0] sat_inc(input logic [STV_W-1:0] v);
    if (v == STV_W'(STARVE_LIMIT)) return v;
    return v + STV_W'(1);
  endfunction

  function automatic logic raw_hazard(input logic [4:0] rs, input logic [31:0] bsy,
                                      input logic cm, input logic [4:0] cm_rd);
    return (rs != 5'd0) && bsy[rs] && !(cm && (cm_rd == rs));
  endfunction

  // Port select: pipeline first, then FIFO head, then direct bypass.
  always_comb begin
    pop       = 1'b0;
    bypass    = 1'b0;
    sel_valid = 1'b0;
    sel_rd    = '0;
    sel_data  = '0;
    if (bus.pipe_wb_valid) begin
      sel_valid = 1'b1;
      sel_rd    = bus.pipe_wb_rd;
      sel_data  = bus.pipe_wb_data;
    end else if (count != '0) begin
      pop       = 1'b1;
      sel_valid = 1'b1;
      sel_rd    = fifo_rd[rd_ptr];
      sel_data  = fifo_data[rd_ptr];
    end else if (bus.ll_wb_valid) begin
      bypass    = 1'b1;
      sel_valid = 1'b1;
      sel_rd    = bus.ll_wb_rd;
      sel_data  = bus.ll_wb_data;
    end
  end

  assign full      = (count == CNT_W'(FIFO_DEPTH));
  assign ll_ready  = !full || pop;
  assign push      = bus.ll_wb_valid && ll_ready && !bypass;
  assign commit    = pop || bypass;
  assign commit_rd = pop ? fifo_rd[rd_ptr] : bus.ll_wb_rd;
  assign reg_write = sel_valid && (sel_rd != 5'd0);

  // Set beats clear on the same register so a reissued destination stays pending.
  always_comb begin
    busy_next = busy_q;
    if (commit) busy_next[commit_rd] = 1'b0;
    if (bus.ll_issue_valid && (bus.ll_issue_rd != 5'd0)) busy_next[bus.ll_issue_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  assign starve_next = (full && bus.pipe_wb_valid) ? sat_inc(starve) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      busy_q      <= '0;
      starve      <= '0;
      pipe_hold_q <= 1'b0;
    end else begin
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      busy_q      <= busy_next;
      starve      <= starve_next;
      pipe_hold_q <= (starve_next == STV_W'(STARVE_LIMIT));
    end
  end

  // Entry storage carries no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd[wr_ptr]   <= bus.ll_wb_rd;
      fifo_data[wr_ptr] <= bus.ll_wb_data;
    end
  end

  assign bus.ll_wb_ready   = ll_ready;
  assign bus.RegWrite      = reg_write;
  assign bus.rd            = reg_write ? sel_rd : 5'd0;
  assign bus.rd_write_data = reg_write ? sel_data : '0;
  assign bus.busy          = busy_q;
  assign bus.pipe_hold     = pipe_hold_q;
  assign bus.src_stall     = raw_hazard(bus.rs1, busy_q, commit, commit_rd) ||
                             raw_hazard(bus.rs2, busy_q, commit, commit_rd);
  assign bus.issue_stall   = bus.ll_issue_valid && (bus.ll_issue_rd != 5'd0) &&
                             busy_q[bus.ll_issue_rd];
endmodule

// File: tb/tb_regfile_wb_sched.sv
// Directed bench for regfile_wb_sched: bypass, collision, backpressure/starvation,
// hazards, x0 handling and mid-operation reset.
module tb_regfile_wb_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  regfile_wb_sched_if bus ();

  regfile_wb_sched #(.FIFO_DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.pipe_wb_valid  = 1'b0; bus.pipe_wb_rd = 5'd0; bus.pipe_wb_data = 32'h0;
    bus.ll_issue_valid = 1'b0; bus.ll_issue_rd = 5'd0;
    bus.ll_wb_valid    = 1'b0; bus.ll_wb_rd = 5'd0; bus.ll_wb_data = 32'h0;
    bus.rs1 = 5'd0; bus.rs2 = 5'd0;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    #1;
    check("rst_ready",     {31'b0, bus.ll_wb_ready}, 32'd1);
    check("rst_hold",      {31'b0, bus.pipe_hold},   32'd0);
    check("rst_src_stall", {31'b0, bus.src_stall},   32'd0);
    check("rst_iss_stall", {31'b0, bus.issue_stall}, 32'd0);
    check("rst_busy",      bus.busy,                 32'h0);
    check("rst_regwrite",  {31'b0, bus.RegWrite},    32'd0);

    // Bypass
    bus.ll_issue_valid = 1'b1; bus.ll_issue_rd = 5'd5;
    #1 check("byp_issue_nostall", {31'b0, bus.issue_stall}, 32'd0);
    tick();
    bus.ll_issue_valid = 1'b0; bus.rs1 = 5'd5;
    #1;
    check("byp_busy_set",  bus.busy, 32'h0000_0020);
    check("byp_raw_stall", {31'b0, bus.src_stall}, 32'd1);
    bus.ll_wb_valid = 1'b1; bus.ll_wb_rd = 5'd5; bus.ll_wb_data = 32'hDEAD_BEEF;
    #1;
    check("byp_regwrite", {31'b0, bus.RegWrite}, 32'd1);
    check("byp_rd",       {27'b0, bus.rd}, 32'd5);
    check("byp_data",     bus.rd_write_data, 32'hDEAD_BEEF);
    check("byp_fwd_nostall", {31'b0, bus.src_stall}, 32'd0);
    tick();
    idle_inputs();
    #1;
    check("byp_busy_clr", bus.busy, 32'h0);
    check("byp_idle_rw",  {31'b0, bus.RegWrite}, 32'd0);
    check("byp_idle_data", bus.rd_write_data, 32'h0);

    // Collision: pipe wins, long-latency result waits in the FIFO
    bus.ll_issue_valid = 1'b1; bus.ll_issue_rd = 5'd7;
    tick();
    bus.ll_issue_valid = 1'b0;
    bus.pipe_wb_valid = 1'b1; bus.pipe_wb_rd = 5'd3; bus.pipe_wb_data = 32'h11;
    bus.ll_wb_valid = 1'b1; bus.ll_wb_rd = 5'd7; bus.ll_wb_data = 32'h22;
    #1;
    check("col_rd",    {27'b0, bus.rd}, 32'd3);
    check("col_data",  bus.rd_write_data, 32'h11);
    check("col_ready", {31'b0, bus.ll_wb_ready}, 32'd1);
    check("col_busy",  bus.busy, 32'h0000_0080);
    tick();
    idle_inputs();
    bus.rs2 = 5'd7;
    #1;
    check("col_pop_rw",   {31'b0, bus.RegWrite}, 32'd1);
    check("col_pop_rd",   {27'b0, bus.rd}, 32'd7);
    check("col_pop_data", bus.rd_write_data, 32'h22);
    check("col_busy_held", bus.busy, 32'h0000_0080);
    check("col_fwd_nostall", {31'b0, bus.src_stall}, 32'd0);
    tick();
    idle_inputs();
    #1;
    check("col_busy_clr", bus.busy, 32'h0);
    check("col_empty_rw", {31'b0, bus.RegWrite}, 32'd0);

    // Full FIFO, backpressure and starvation bubble
    bus.pipe_wb_valid = 1'b1; bus.pipe_wb_rd = 5'd1; bus.pipe_wb_data = 32'h100;
    bus.ll_wb_valid = 1'b1; bus.ll_wb_rd = 5'd10; bus.ll_wb_data = 32'hA;
    #1 check("full_acc1", {31'b0, bus.ll_wb_ready}, 32'd1);
    tick();
    bus.ll_wb_rd = 5'd11; bus.ll_wb_data = 32'hB;
    #1 check("full_acc2", {31'b0, bus.ll_wb_ready}, 32'd1);
    tick();
    bus.ll_wb_rd = 5'd12; bus.ll_wb_data = 32'hC;
    #1;
    check("full_noready", {31'b0, bus.ll_wb_ready}, 32'd0);
    check("full_pipe_rd", {27'b0, bus.rd}, 32'd1);
    tick(); tick(); tick();
    check("starve_3", {31'b0, bus.pipe_hold}, 32'd0);
    tick();
    check("starve_4", {31'b0, bus.pipe_hold}, 32'd1);
    tick();
    check("starve_sat", {31'b0, bus.pipe_hold}, 32'd1);
    bus.pipe_wb_valid = 1'b0;
    #1;
    check("drain1_rd",    {27'b0, bus.rd}, 32'd10);
    check("drain1_data",  bus.rd_write_data, 32'hA);
    check("drain1_ready", {31'b0, bus.ll_wb_ready}, 32'd1);
    tick();
    idle_inputs();
    #1;
    check("drain_hold_fall", {31'b0, bus.pipe_hold}, 32'd0);
    check("drain2_rd",   {27'b0, bus.rd}, 32'd11);
    check("drain2_data", bus.rd_write_data, 32'hB);
    tick();
    check("drain3_rd",   {27'b0, bus.rd}, 32'd12);
    check("drain3_data", bus.rd_write_data, 32'hC);
    tick();
    check("drain_done_rw", {31'b0, bus.RegWrite}, 32'd0);

    // Hazards
    bus.ll_issue_valid = 1'b1; bus.ll_issue_rd = 5'd9;
    tick();
    bus.ll_issue_valid = 1'b0;
    bus.rs2 = 5'd9;
    #1 check("haz_raw_rs2", {31'b0, bus.src_stall}, 32'd1);
    bus.ll_issue_valid = 1'b1; bus.ll_issue_rd = 5'd9;
    #1 check("haz_waw", {31'b0, bus.issue_stall}, 32'd1);
    bus.ll_issue_rd = 5'd0;
    #1 check("haz_waw_x0", {31'b0, bus.issue_stall}, 32'd0);
    bus.ll_issue_valid = 1'b0; bus.rs1 = 5'd0; bus.rs2 = 5'd0;
    #1 check("haz_rs0", {31'b0, bus.src_stall}, 32'd0);
    bus.ll_wb_valid = 1'b1; bus.ll_wb_rd = 5'd9; bus.ll_wb_data = 32'h99;
    tick();
    idle_inputs();
    #1 check("haz_busy_clr", bus.busy, 32'h0);

    // x0 result is consumed without a write
    bus.ll_issue_valid = 1'b1; bus.ll_issue_rd = 5'd4;
    tick();
    bus.ll_issue_valid = 1'b0;
    bus.ll_wb_valid = 1'b1; bus.ll_wb_rd = 5'd0; bus.ll_wb_data = 32'h5;
    #1;
    check("x0_rw",    {31'b0, bus.RegWrite}, 32'd0);
    check("x0_rd",    {27'b0, bus.rd}, 32'd0);
    check("x0_data",  bus.rd_write_data, 32'h0);
    check("x0_ready", {31'b0, bus.ll_wb_ready}, 32'd1);
    tick();
    idle_inputs();
    #1;
    check("x0_busy", bus.busy, 32'h0000_0010);
    check("x0_not_queued", {31'b0, bus.RegWrite}, 32'd0);
    bus.ll_wb_valid = 1'b1; bus.ll_wb_rd = 5'd4; bus.ll_wb_data = 32'h44;
    tick();
    idle_inputs();

    // Mid-operation reset discards queued results and busy bits
    bus.ll_issue_valid = 1'b1; bus.ll_issue_rd = 5'd1;
    tick();
    bus.ll_issue_rd = 5'd7;
    tick();
    bus.ll_issue_valid = 1'b0;
    bus.pipe_wb_valid = 1'b1; bus.pipe_wb_rd = 5'd2; bus.pipe_wb_data = 32'h2;
    bus.ll_wb_valid = 1'b1; bus.ll_wb_rd = 5'd1; bus.ll_wb_data = 32'h111;
    tick();
    bus.ll_wb_rd = 5'd7; bus.ll_wb_data = 32'h777;
    tick();
    bus.ll_wb_valid = 1'b0;
    #1;
    check("mid_full",  {31'b0, bus.ll_wb_ready}, 32'd0);
    check("mid_busy",  bus.busy, 32'h0000_0082);
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("mid_rst_busy",  bus.busy, 32'h0);
    check("mid_rst_ready", {31'b0, bus.ll_wb_ready}, 32'd1);
    check("mid_rst_rw",    {31'b0, bus.RegWrite}, 32'd0);
    tick();
    check("mid_rst_rw2",   {31'b0, bus.RegWrite}, 32'd0);
    check("mid_rst_hold",  {31'b0, bus.pipe_hold}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
